// File: rtl/fsx_pkg.sv
// Shared constants, widths and state encoding for the pixel fill engine.
package fsx_pkg;
  localparam int FSX_H_RES = 320;
  localparam int FSX_V_RES = 240;
  localparam int ADDR_W    = 17;
  localparam int COLOR_W   = 24;
  localparam int X_W       = 9;
  localparam int Y_W       = 8;
  localparam int SUM_W     = 10;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_FRAME = 3'd1,
    CLIP       = 3'd2,
    FILL       = 3'd3,
    DONE       = 3'd4
  } fsx_state_e;

  function automatic logic [SUM_W-1:0] fsx_min(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/pixel_fill_clip.sv
// Combinational rectangle clip: exclusive end coordinates and an empty flag.
module pixel_fill_clip
  import fsx_pkg::*;
#(
  parameter int H_RES = FSX_H_RES,
  parameter int V_RES = FSX_V_RES
) (
  input  logic [X_W-1:0]   i_x0,
  input  logic [Y_W-1:0]   i_y0,
  input  logic [X_W-1:0]   i_w,
  input  logic [Y_W-1:0]   i_h,
  output logic [SUM_W-1:0] o_x_end,
  output logic [SUM_W-1:0] o_y_end,
  output logic             o_empty
);
  localparam logic [SUM_W-1:0] H_LIM = SUM_W'(H_RES);
  localparam logic [SUM_W-1:0] V_LIM = SUM_W'(V_RES);

  logic [SUM_W-1:0] w_x_sum;
  logic [SUM_W-1:0] w_y_sum;

  // Sums are one bit wider than the operands so they never wrap.
  always_comb begin
    w_x_sum = {1'b0, i_x0} + {1'b0, i_w};
    w_y_sum = {2'b00, i_y0} + {2'b00, i_h};
    o_x_end = fsx_min(w_x_sum, H_LIM);
    o_y_end = fsx_min(w_y_sum, V_LIM);
    o_empty = ({1'b0, i_x0} >= H_LIM) || ({2'b00, i_y0} >= V_LIM) ||
              (i_w == 9'd0) || (i_h == 8'd0);
  end
endmodule

// File: rtl/pixel_fill_engine.sv
// Rectangle fill engine: clips a command to the pixel plane and writes it
// in raster order through a valid/grant VRAM write port.
module pixel_fill_engine
  import fsx_pkg::*;
#(
  parameter int H_RES = FSX_H_RES,
  parameter int V_RES = FSX_V_RES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [X_W-1:0]     cmd_x0,
  input  logic [Y_W-1:0]     cmd_y0,
  input  logic [X_W-1:0]     cmd_w,
  input  logic [Y_W-1:0]     cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               cmd_sync,
  input  logic               frameDrawn,
  output logic [ADDR_W-1:0]  vramPX_addr,
  output logic [COLOR_W-1:0] vramPX_d,
  output logic               vramPX_we,
  input  logic               vramPX_grant,
  output logic               busy,
  output logic               done
);
  localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_RES);

  fsx_state_e         r_state;
  logic               r_cmd_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [COLOR_W-1:0] r_d;
  logic [X_W-1:0]     r_x0;
  logic [Y_W-1:0]     r_y0;
  logic [X_W-1:0]     r_w;
  logic [Y_W-1:0]     r_h;
  logic [COLOR_W-1:0] r_color;
  logic               r_sync;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [SUM_W-1:0]   r_x_end;
  logic [SUM_W-1:0]   r_y_end;
  logic [ADDR_W-1:0]  r_row_base;

  logic [SUM_W-1:0]   w_x_end;
  logic [SUM_W-1:0]   w_y_end;
  logic               w_empty;
  logic               w_last_col;
  logic               w_last_row;
  logic [ADDR_W-1:0]  w_base0;

  pixel_fill_clip #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_clip (
    .i_x0    (r_x0),
    .i_y0    (r_y0),
    .i_w     (r_w),
    .i_h     (r_h),
    .o_x_end (w_x_end),
    .o_y_end (w_y_end),
    .o_empty (w_empty)
  );

  // The only multiply is the first row base, formed once in CLIP.
  always_comb begin
    w_base0    = ADDR_W'(r_y0) * H_STEP;
    w_last_col = (({1'b0, r_x} + 10'd1) == r_x_end);
    w_last_row = (({2'b00, r_y} + 10'd1) == r_y_end);
  end

  // Command sequencing, clip registration and pixel stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_d         <= '0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_w         <= '0;
      r_h         <= '0;
      r_color     <= '0;
      r_sync      <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_x_end     <= '0;
      r_y_end     <= '0;
      r_row_base  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_x0        <= cmd_x0;
            r_y0        <= cmd_y0;
            r_w         <= cmd_w;
            r_h         <= cmd_h;
            r_color     <= cmd_color;
            r_sync      <= cmd_sync;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= cmd_sync ? WAIT_FRAME : CLIP;
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT_FRAME: begin
          if (frameDrawn) begin
            r_state <= CLIP;
          end else begin
            r_state <= WAIT_FRAME;
          end
        end
        CLIP: begin
          r_x_end <= w_x_end;
          r_y_end <= w_y_end;
          if (w_empty) begin
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_x        <= r_x0;
            r_y        <= r_y0;
            r_row_base <= w_base0;
            r_addr     <= w_base0 + ADDR_W'(r_x0);
            r_d        <= r_color;
            r_we       <= 1'b1;
            r_state    <= FILL;
          end
        end
        FILL: begin
          if (r_we && vramPX_grant) begin
            if (w_last_col && w_last_row) begin
              r_we    <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else if (w_last_col) begin
              r_x        <= r_x0;
              r_y        <= r_y + 8'd1;
              r_row_base <= r_row_base + H_STEP;
              r_addr     <= r_row_base + H_STEP + ADDR_W'(r_x0);
            end else begin
              r_x    <= r_x + 9'd1;
              r_addr <= r_addr + 17'd1;
            end
          end else begin
            r_state <= FILL;
          end
        end
        DONE: begin
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: begin
          r_we        <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign vramPX_we   = r_we;
  assign vramPX_addr = r_addr;
  assign vramPX_d    = r_d;
endmodule
